ball_motion: RTL and testbench

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/ball_motion.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_ball_motion.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// ball_motion: breakout-style ball position engine.
// Holds the ball on the paddle while idle, moves it diagonally on each
// motion tick once launched, and reflects it off the walls, the paddle and
// a single brick. A miss at the bottom edge parks the ball in LOST for a
// fixed number of ticks, then the ball returns to the paddle.
// Direction flags: dx_pos_r=1 means moving right, dy_pos_r=1 means moving down.
module ball_motion #(
    parameter int BALL_SIZE  = 8,
    parameter int STEP       = 2,
    parameter int TICK_DIV   = 1000000,
    parameter int PADDLE_W   = 64,
    parameter int BRICK_W    = 32,
    parameter int BRICK_H    = 8,
    parameter int LOST_TICKS = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] paddle_x,
    input  logic [9:0] paddle_y,
    input  logic [9:0] brick_x,
    input  logic [9:0] brick_y,
    input  logic       brick_alive,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       hit,
    output logic       lost,
    output logic       moving
);

    // Counter widths; a divider of 1 still needs a one-bit counter.
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LOST_W = (LOST_TICKS > 1) ? $clog2(LOST_TICKS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_TICKS - 1);

    // All geometry is evaluated in 11 bits so sums past 1023 do not wrap.
    localparam logic [10:0] BS_C     = 11'(BALL_SIZE);
    localparam logic [10:0] STEP_C   = 11'(STEP);
    localparam logic [10:0] PW_C     = 11'(PADDLE_W);
    localparam logic [10:0] BW_C     = 11'(BRICK_W);
    localparam logic [10:0] BH_C     = 11'(BRICK_H);
    localparam logic [10:0] SCR_W_C  = 11'd640;
    localparam logic [10:0] SCR_H_C  = 11'd480;
    localparam logic [10:0] X_MAX_C  = SCR_W_C - BS_C;
    localparam logic [10:0] Y_MAX_C  = SCR_H_C - BS_C;

    localparam logic [9:0] RST_X_C = 10'd316;
    localparam logic [9:0] RST_Y_C = 10'd288;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_LOST = 2'd2
    } state_t;

    // Saturate an 11-bit coordinate to the on-screen maximum and narrow it.
    function automatic logic [9:0] sat10(input logic [10:0] v, input logic [10:0] maxv);
        return 10'((v > maxv) ? maxv : v);
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic [TICK_W-1:0]   tick_cnt_r;
    logic [LOST_W-1:0]   lost_cnt_r;
    logic [LOST_W-1:0]   lost_cnt_nx_s;
    logic [9:0]          ball_x_r;
    logic [9:0]          ball_y_r;
    logic [9:0]          ball_x_nx_s;
    logic [9:0]          ball_y_nx_s;
    logic                dx_pos_r;
    logic                dy_pos_r;
    logic                dx_pos_nx_s;
    logic                dy_pos_nx_s;
    logic                hit_r;
    logic                lost_r;
    logic                moving_r;
    logic                hit_nx_s;
    logic                lost_nx_s;
    logic                moving_nx_s;

    logic                tick_s;
    logic                lost_last_s;
    logic [10:0]         x_ext_s;
    logic [10:0]         y_ext_s;
    logic [10:0]         px_ext_s;
    logic [10:0]         py_ext_s;
    logic [10:0]         bx_ext_s;
    logic [10:0]         by_ext_s;
    logic [10:0]         idle_x_s;
    logic [10:0]         idle_y_s;
    logic [10:0]         x_res_s;
    logic                dx_res_s;
    logic [10:0]         y_try_s;
    logic [10:0]         y_res_s;
    logic                dy_res_s;
    logic                paddle_evt_s;
    logic                brick_evt_s;
    logic                top_evt_s;
    logic                bottom_evt_s;
    logic                hit_evt_s;
    logic                lost_evt_s;

    assign tick_s      = (tick_cnt_r == TICK_LAST);
    assign lost_last_s = (lost_cnt_r == LOST_LAST);

    assign x_ext_s  = {1'b0, ball_x_r};
    assign y_ext_s  = {1'b0, ball_y_r};
    assign px_ext_s = {1'b0, paddle_x};
    assign py_ext_s = {1'b0, paddle_y};
    assign bx_ext_s = {1'b0, brick_x};
    assign by_ext_s = {1'b0, brick_y};

    // Resting position centred on top of the paddle while idle.
    always_comb begin
        idle_x_s = px_ext_s + (PW_C / 11'd2) - (BS_C / 11'd2);
        if (py_ext_s < BS_C) begin
            idle_y_s = 11'd0;
        end else begin
            idle_y_s = py_ext_s - BS_C;
        end
    end

    // Horizontal step with left/right wall reflection.
    always_comb begin
        x_res_s  = x_ext_s;
        dx_res_s = dx_pos_r;
        if (!dx_pos_r && (x_ext_s < STEP_C)) begin
            x_res_s  = 11'd0;
            dx_res_s = 1'b1;
        end else if (dx_pos_r && ((x_ext_s + BS_C + STEP_C) > SCR_W_C)) begin
            x_res_s  = X_MAX_C;
            dx_res_s = 1'b0;
        end else if (dx_pos_r) begin
            x_res_s  = x_ext_s + STEP_C;
        end else begin
            x_res_s  = x_ext_s - STEP_C;
        end
    end

    // Unconditional vertical step, used for the brick overlap test and as
    // the result when no vertical event applies.
    always_comb begin
        if (dy_pos_r) begin
            y_try_s = y_ext_s + STEP_C;
        end else if (y_ext_s < STEP_C) begin
            y_try_s = 11'd0;
        end else begin
            y_try_s = y_ext_s - STEP_C;
        end
    end

    // Vertical event detection against paddle, brick, top and bottom.
    always_comb begin
        paddle_evt_s = dy_pos_r
                     && ((y_ext_s + BS_C) <= py_ext_s)
                     && ((y_ext_s + BS_C + STEP_C) >= py_ext_s)
                     && ((x_ext_s + BS_C) > px_ext_s)
                     && (x_ext_s < (px_ext_s + PW_C));
        brick_evt_s  = brick_alive
                     && (x_res_s < (bx_ext_s + BW_C))
                     && ((x_res_s + BS_C) > bx_ext_s)
                     && (y_try_s < (by_ext_s + BH_C))
                     && ((y_try_s + BS_C) > by_ext_s);
        top_evt_s    = !dy_pos_r && (y_ext_s < STEP_C);
        bottom_evt_s = dy_pos_r && ((y_ext_s + BS_C + STEP_C) >= SCR_H_C);
    end

    // Resolve one vertical event by priority: paddle, brick, top, bottom.
    always_comb begin
        y_res_s    = y_ext_s;
        dy_res_s   = dy_pos_r;
        hit_evt_s  = 1'b0;
        lost_evt_s = 1'b0;
        if (paddle_evt_s) begin
            y_res_s  = py_ext_s - BS_C;
            dy_res_s = 1'b0;
        end else if (brick_evt_s) begin
            dy_res_s  = ~dy_pos_r;
            hit_evt_s = 1'b1;
        end else if (top_evt_s) begin
            y_res_s  = 11'd0;
            dy_res_s = 1'b1;
        end else if (bottom_evt_s) begin
            lost_evt_s = 1'b1;
        end else begin
            y_res_s = y_try_s;
        end
    end

    // Motion tick divider; free-running in every state, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_MOVE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (tick_s && lost_evt_s) begin
                    state_nx_s = ST_LOST;
                end else begin
                    state_nx_s = ST_MOVE;
                end
            end
            ST_LOST: begin
                if (tick_s && lost_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_LOST;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next ball position, direction, pulses and LOST count.
    always_comb begin
        ball_x_nx_s   = ball_x_r;
        ball_y_nx_s   = ball_y_r;
        dx_pos_nx_s   = dx_pos_r;
        dy_pos_nx_s   = dy_pos_r;
        hit_nx_s      = 1'b0;
        lost_nx_s     = 1'b0;
        lost_cnt_nx_s = lost_cnt_r;
        case (state_r)
            ST_IDLE: begin
                ball_x_nx_s   = sat10(idle_x_s, X_MAX_C);
                ball_y_nx_s   = sat10(idle_y_s, Y_MAX_C);
                dx_pos_nx_s   = 1'b1;
                dy_pos_nx_s   = 1'b0;
                lost_cnt_nx_s = '0;
            end
            ST_MOVE: begin
                lost_cnt_nx_s = '0;
                if (tick_s) begin
                    ball_x_nx_s = sat10(x_res_s, X_MAX_C);
                    ball_y_nx_s = sat10(y_res_s, Y_MAX_C);
                    dx_pos_nx_s = dx_res_s;
                    dy_pos_nx_s = dy_res_s;
                    hit_nx_s    = hit_evt_s;
                    lost_nx_s   = lost_evt_s;
                end else begin
                    ball_x_nx_s = ball_x_r;
                    ball_y_nx_s = ball_y_r;
                end
            end
            ST_LOST: begin
                if (tick_s && lost_last_s) begin
                    lost_cnt_nx_s = '0;
                end else if (tick_s) begin
                    lost_cnt_nx_s = lost_cnt_r + LOST_W'(1);
                end else begin
                    lost_cnt_nx_s = lost_cnt_r;
                end
            end
            default: begin
                lost_cnt_nx_s = '0;
            end
        endcase
        moving_nx_s = (state_nx_s == ST_MOVE);
    end

    // Registered ball datapath and output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            ball_x_r   <= RST_X_C;
            ball_y_r   <= RST_Y_C;
            dx_pos_r   <= 1'b1;
            dy_pos_r   <= 1'b0;
            lost_cnt_r <= '0;
            hit_r      <= 1'b0;
            lost_r     <= 1'b0;
            moving_r   <= 1'b0;
        end else begin
            ball_x_r   <= ball_x_nx_s;
            ball_y_r   <= ball_y_nx_s;
            dx_pos_r   <= dx_pos_nx_s;
            dy_pos_r   <= dy_pos_nx_s;
            lost_cnt_r <= lost_cnt_nx_s;
            hit_r      <= hit_nx_s;
            lost_r     <= lost_nx_s;
            moving_r   <= moving_nx_s;
        end
    end

    assign ball_x = ball_x_r;
    assign ball_y = ball_y_r;
    assign hit    = hit_r;
    assign lost   = lost_r;
    assign moving = moving_r;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with a short tick divider.
module tb_ball_motion;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] paddle_x;
    logic [9:0] paddle_y;
    logic [9:0] brick_x;
    logic [9:0] brick_y;
    logic       brick_alive;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       hit;
    logic       lost;
    logic       moving;

    always #5 clk = ~clk;

    ball_motion #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .paddle_x    (paddle_x),
        .paddle_y    (paddle_y),
        .brick_x     (brick_x),
        .brick_y     (brick_y),
        .brick_alive (brick_alive),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .hit         (hit),
        .lost        (lost),
        .moving      (moving)
    );

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic [9:0] ex;
        logic [9:0] ey;
    } idle_vec_t;

    idle_vec_t tbl[5];

    int total = 0;
    int bad = 0;
    int phase = 0;
    bit last_tick = 1'b0;
    int hit_seen = 0;
    int lost_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; tracks the divider phase (counter value) the DUT should hold.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            phase = 0;
            last_tick = 1'b0;
        end else begin
            last_tick = (phase == TD - 1);
            phase = (phase + 1) % TD;
        end
        #1;
        if (hit === 1'b1) hit_seen++;
        if (lost === 1'b1) lost_seen++;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_tick && n < 2 * TD);
        if (!last_tick) begin
            total++;
            bad++;
            $display("FAIL tick_wait: got no tick expected tick within %0d cycles", 2 * TD);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{px: 10'd288, py: 10'd296, ex: 10'd316, ey: 10'd288};
        tbl[1] = '{px: 10'd0,   py: 10'd100, ex: 10'd28,  ey: 10'd92};
        tbl[2] = '{px: 10'd600, py: 10'd479, ex: 10'd628, ey: 10'd471};
        tbl[3] = '{px: 10'd100, py: 10'd8,   ex: 10'd128, ey: 10'd0};
        tbl[4] = '{px: 10'd350, py: 10'd50,  ex: 10'd378, ey: 10'd42};

        reset = 1'b1; start = 1'b0;
        paddle_x = 10'd0; paddle_y = 10'd0;
        brick_x = 10'd0; brick_y = 10'd0; brick_alive = 1'b0;

        // Reset values.
        do_reset();
        check("rst_x", ball_x, 316);
        check("rst_y", ball_y, 288);
        check("rst_moving", moving, 0);
        check("rst_hit", hit, 0);
        check("rst_lost", lost, 0);

        // Ball follows the paddle while idle.
        for (int i = 0; i < 5; i++) begin
            paddle_x = tbl[i].px;
            paddle_y = tbl[i].py;
            step();
            check("idle_x", ball_x, tbl[i].ex);
            check("idle_y", ball_y, tbl[i].ey);
            check("idle_moving", moving, 0);
        end

        // Launch and first motion tick.
        paddle_x = 10'd288; paddle_y = 10'd296;
        do_reset();
        launch();
        check("launch_moving", moving, 1);
        wait_tick();
        check("tick1_x", ball_x, 318);
        check("tick1_y", ball_y, 286);
        check("tick1_moving", moving, 1);

        // Corner: right wall and top wall in the same tick.
        paddle_x = 10'd583; paddle_y = 10'd29;
        do_reset();
        step();
        launch();
        repeat (10) wait_tick();
        check("corner_pre_x", ball_x, 631);
        check("corner_pre_y", ball_y, 1);
        wait_tick();
        check("corner_x", ball_x, 632);
        check("corner_y", ball_y, 0);
        wait_tick();
        check("corner_after_x", ball_x, 630);
        check("corner_after_y", ball_y, 2);

        // Brick collision: one hit pulse, y held, dy inverted.
        paddle_x = 10'd288; paddle_y = 10'd296;
        brick_x = 10'd330; brick_y = 10'd260; brick_alive = 1'b1;
        do_reset();
        step();
        launch();
        hit_seen = 0;
        repeat (10) wait_tick();
        check("brick_pre_hits", hit_seen, 0);
        check("brick_pre_y", ball_y, 268);
        wait_tick();
        check("brick_hit", hit, 1);
        check("brick_x", ball_x, 338);
        check("brick_y_hold", ball_y, 268);
        step();
        check("brick_hit_drop", hit, 0);
        wait_tick();
        check("brick_after_x", ball_x, 340);
        check("brick_after_y", ball_y, 270);
        check("brick_hit_count", hit_seen, 1);

        // Same path with the brick absent.
        brick_alive = 1'b0;
        do_reset();
        step();
        launch();
        hit_seen = 0;
        repeat (12) wait_tick();
        check("nobrick_hits", hit_seen, 0);
        check("nobrick_x", ball_x, 340);
        check("nobrick_y", ball_y, 264);

        // Ball lost at the bottom, LOST duration, relaunch with held start.
        paddle_x = 10'd288; paddle_y = 10'd479;
        brick_x = 10'd316; brick_y = 10'd461; brick_alive = 1'b1;
        do_reset();
        step();
        check("lostseq_idle_y", ball_y, 471);
        launch();
        wait_tick();
        check("lostseq_t1_y", ball_y, 469);
        wait_tick();
        check("lostseq_flip_hit", hit, 1);
        check("lostseq_flip_y", ball_y, 469);
        paddle_x = 10'd0;
        brick_alive = 1'b0;
        lost_seen = 0;
        wait_tick();
        check("lostseq_t3_y", ball_y, 471);
        wait_tick();
        check("lost_pulse", lost, 1);
        check("lost_moving", moving, 0);
        check("lost_y_hold", ball_y, 471);
        step();
        check("lost_drop", lost, 0);
        start = 1'b1;
        paddle_x = 10'd100; paddle_y = 10'd300;
        repeat (49) wait_tick();
        check("lost_frozen_y", ball_y, 471);
        check("lost_ignores_start", moving, 0);
        wait_tick();
        step();
        start = 1'b0;
        check("relaunch_moving", moving, 1);
        check("relaunch_x", ball_x, 128);
        check("relaunch_y", ball_y, 292);
        check("lost_count", lost_seen, 1);

        // Reset on a tick that would otherwise produce a brick hit.
        paddle_x = 10'd100; paddle_y = 10'd300;
        brick_x = 10'd128; brick_y = 10'd282; brick_alive = 1'b1;
        do_reset();
        step();
        launch();
        hit_seen = 0;
        wait_tick();
        check("rstmove_t1_y", ball_y, 290);
        for (int k = 0; k < TD && phase != TD - 1; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmove_x", ball_x, 316);
        check("rstmove_y", ball_y, 288);
        check("rstmove_moving", moving, 0);
        check("rstmove_hit", hit, 0);
        check("rstmove_lost", lost, 0);
        check("rstmove_hit_count", hit_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
